// File: rtl/sec32_pkg.sv
// rtl/sec32_pkg.sv - shared constants, skid-state enum and check-bit generator for sec32 encoding
package sec32_pkg;

    localparam int DATA_W  = 32;
    localparam int CHK_W   = 8;
    localparam int ENTRY_W = DATA_W + CHK_W;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    function automatic logic [CHK_W-1:0] sec32_check(input logic [DATA_W-1:0] d);
        logic [CHK_W-1:0] c;
        c[0] = (^d[23:16]) ^ d[0] ^ d[4] ^ d[8]  ^ d[12];
        c[1] = (^d[31:24]) ^ d[1] ^ d[5] ^ d[9]  ^ d[13];
        c[2] = (^d[19:16]) ^ (^d[27:24]) ^ d[2] ^ d[6] ^ d[10] ^ d[14];
        c[3] = (^d[23:20]) ^ (^d[31:28]) ^ d[3] ^ d[7] ^ d[11] ^ d[15];
        c[4] = (^d[7:0])   ^ d[16] ^ d[20] ^ d[24] ^ d[28];
        c[5] = (^d[15:8])  ^ d[17] ^ d[21] ^ d[25] ^ d[29];
        c[6] = (^d[3:0])   ^ (^d[11:8])  ^ d[18] ^ d[22] ^ d[26] ^ d[30];
        c[7] = (^d[7:4])   ^ (^d[15:12]) ^ d[19] ^ d[23] ^ d[27] ^ d[31];
        return c;
    endfunction

endpackage

// File: rtl/sec32_skid.sv
// rtl/sec32_skid.sv - two-entry skid buffer with registered in_ready and out_valid
module sec32_skid
    import sec32_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ENTRY_W-1:0] in_entry,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ENTRY_W-1:0] out_entry
);

    skid_state_t        state, state_nxt;
    logic [ENTRY_W-1:0] head, tail;
    logic               load_head, head_from_tail, load_tail;
    logic               acc, emit;

    assign acc       = in_valid && in_ready;
    assign emit      = out_valid && out_ready;
    assign out_entry = head;

    // head is always the word on the output; tail only holds the overflow word in FULL
    always_comb begin
        state_nxt      = state;
        load_head      = 1'b0;
        head_from_tail = 1'b0;
        load_tail      = 1'b0;
        case (state)
            SKID_EMPTY: begin
                if (acc) begin
                    load_head = 1'b1;
                    state_nxt = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (acc && emit) begin
                    load_head = 1'b1;
                end else if (acc) begin
                    load_tail = 1'b1;
                    state_nxt = SKID_FULL;
                end else if (emit) begin
                    state_nxt = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (emit) begin
                    load_head      = 1'b1;
                    head_from_tail = 1'b1;
                    state_nxt      = SKID_ONE;
                end
            end
            default: state_nxt = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SKID_EMPTY;
            head      <= '0;
            tail      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != SKID_FULL);
            out_valid <= (state_nxt != SKID_EMPTY);
            if (load_head) begin
                head <= head_from_tail ? tail : in_entry;
            end
            if (load_tail) begin
                tail <= in_entry;
            end
        end
    end

endmodule

// File: rtl/sec32_encoder_pipe.sv
// rtl/sec32_encoder_pipe.sv - SEC check-bit encoder with error injection and skid-buffered output
module sec32_encoder_pipe
    import sec32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [7:0]        out_check,
    output logic              out_chk_en,
    input  logic              inj_en,
    input  logic [5:0]        inj_bit,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  inj_cnt
);

    logic [CHK_W-1:0]   check;
    logic               do_flip;
    logic [ENTRY_W-1:0] flip_mask;
    logic [ENTRY_W-1:0] in_entry, out_entry;
    logic               acc, emit;

    // check bits are taken from the clean word, so an injected flip shows up as a syndrome
    assign check     = sec32_check(in_data);
    assign do_flip   = inj_en && (inj_bit < 6'd40);
    assign flip_mask = do_flip ? (ENTRY_W'(1) << inj_bit) : '0;
    assign in_entry  = {check, in_data} ^ flip_mask;

    assign acc  = in_valid && in_ready;
    assign emit = out_valid && out_ready;

    sec32_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_entry  (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_entry (out_entry)
    );

    assign {out_check, out_data} = out_entry;
    assign out_chk_en            = out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            inj_cnt  <= '0;
        end else begin
            if (emit) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (acc && do_flip) begin
                inj_cnt <= inj_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sec32_encoder_pipe.sv
// tb/tb_sec32_encoder_pipe.sv - scoreboard bench for sec32_encoder_pipe with SEC decoder model
module tb_sec32_encoder_pipe;
    import sec32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_check;
    logic        out_chk_en;
    logic        inj_en;
    logic [5:0]  inj_bit;
    logic [15:0] word_cnt, inj_cnt;

    sec32_encoder_pipe #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_check  (out_check),
        .out_chk_en (out_chk_en),
        .inj_en     (inj_en),
        .inj_bit    (inj_bit),
        .word_cnt   (word_cnt),
        .inj_cnt    (inj_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] orig;
        logic [39:0] exp;
    } sb_t;

    sb_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_words = 0;
    logic [15:0] model_injs  = 0;

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sec_decode(input logic [31:0] d, input logic [7:0] c);
        logic [7:0]  s;
        logic [31:0] r;
        r = d;
        s = sec32_check(d) ^ c;
        for (int k = 0; k < 32; k++) begin
            if (s != 8'h00 && sec32_check(32'h1 << k) == s) r[k] = ~r[k];
        end
        return r;
    endfunction

    // scoreboard: pop on emit, push on accept, both sampled at the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            model_words = 0;
            model_injs  = 0;
        end else begin
            if (out_valid) check64("chk_en", {63'd0, out_chk_en}, 64'd1);
            if (out_valid && out_ready) begin
                model_words = model_words + 1'b1;
                if (sb.size() == 0) begin
                    check64("unexpected_word", 64'd1, 64'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check64("out_word", {24'd0, out_check, out_data}, {24'd0, e.exp});
                    check64("decoded", {32'd0, sec_decode(out_data, out_check)}, {32'd0, e.orig});
                end
            end
            if (in_valid && in_ready) begin
                sb_t e;
                logic [39:0] m;
                m = '0;
                if (inj_en && inj_bit < 6'd40) begin
                    m[inj_bit] = 1'b1;
                    model_injs = model_injs + 1'b1;
                end
                e.orig = in_data;
                e.exp  = {sec32_check(in_data), in_data} ^ m;
                sb.push_back(e);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [31:0] enc_data [4];
    logic [7:0]  enc_chk  [4];
    int          acc_n;
    logic        r;

    initial begin
        enc_data[0] = 32'h0000_0000; enc_chk[0] = 8'h00;
        enc_data[1] = 32'h0000_0001; enc_chk[1] = 8'h51;
        enc_data[2] = 32'h8000_0000; enc_chk[2] = 8'h8A;
        enc_data[3] = 32'hFFFF_FFFF; enc_chk[3] = 8'h00;

        rst_n = 1'b0; in_valid = 0; in_data = 0; out_ready = 1; inj_en = 0; inj_bit = 0;
        #12;
        check64("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check64("rst_chk_en", {63'd0, out_chk_en}, 64'd0);
        check64("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check64("rst_out_word", {24'd0, out_check, out_data}, 64'd0);
        check64("rst_word_cnt", {48'd0, word_cnt}, 64'd0);
        check64("rst_inj_cnt", {48'd0, inj_cnt}, 64'd0);
        tick();
        rst_n = 1'b1;

        // encoding with no backpressure, one-cycle latency
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_data = enc_data[i];
            tick();
            in_valid = 0;
            check64("lat_valid", {63'd0, out_valid}, 64'd1);
            check64("enc_check", {56'd0, out_check}, {56'd0, enc_chk[i]});
            check64("enc_data", {32'd0, out_data}, {32'd0, enc_data[i]});
            tick();
        end
        check64("enc_word_cnt", {48'd0, word_cnt}, 64'd4);

        // backpressure: only two words fit
        do_reset();
        out_ready = 0; in_valid = 1; in_data = 32'h1234_0000; acc_n = 0;
        for (int i = 0; i < 3; i++) begin
            r = in_ready;
            tick();
            if (r) acc_n++;
            in_data = 32'h1234_0001 + i;
        end
        check64("bp_accepts", acc_n, 64'd2);
        check64("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check64("bp_out_valid", {63'd0, out_valid}, 64'd1);
        in_valid = 0; out_ready = 1;
        tick(); tick();
        check64("bp_word_cnt", {48'd0, word_cnt}, 64'd2);
        check64("bp_drained", {63'd0, out_valid}, 64'd0);

        // error injection
        in_valid = 1; in_data = 32'h1; inj_en = 1; inj_bit = 6'd5;
        tick();
        in_valid = 0; inj_en = 0;
        check64("inj_data", {32'd0, out_data}, 64'h21);
        check64("inj_check", {56'd0, out_check}, 64'h51);
        check64("inj_cnt1", {48'd0, inj_cnt}, 64'd1);
        tick();
        in_valid = 1; inj_en = 1; inj_bit = 6'd45;
        tick();
        in_valid = 0; inj_en = 0;
        check64("noinj_data", {32'd0, out_data}, 64'h1);
        check64("noinj_cnt", {48'd0, inj_cnt}, 64'd1);
        tick();
        in_valid = 1; inj_en = 1; inj_bit = 6'd35;
        tick();
        in_valid = 0; inj_en = 0;
        check64("inj_chkbit", {56'd0, out_check}, 64'h59);
        check64("inj_cnt2", {48'd0, inj_cnt}, 64'd2);
        inj_en = 1; inj_bit = 6'd3;
        tick(); tick();
        inj_en = 0;
        check64("inj_noacc_cnt", {48'd0, inj_cnt}, 64'd2);

        // reset while FULL
        out_ready = 0; in_valid = 1; in_data = 32'hDEAD_BEEF;
        tick(); tick();
        in_valid = 0;
        check64("full_in_ready", {63'd0, in_ready}, 64'd0);
        #2 rst_n = 0;
        #1;
        check64("rstf_out_valid", {63'd0, out_valid}, 64'd0);
        check64("rstf_word_cnt", {48'd0, word_cnt}, 64'd0);
        check64("rstf_in_ready", {63'd0, in_ready}, 64'd1);
        tick(); tick();
        rst_n = 1; out_ready = 1;
        tick(); tick(); tick();
        check64("rstf_no_stale", {63'd0, out_valid}, 64'd0);
        check64("rstf_cnt_after", {48'd0, word_cnt}, 64'd0);

        // closed loop with random single-bit injections
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            inj_en    = $urandom_range(0, 1);
            inj_bit   = 6'($urandom_range(0, 39));
            tick();
        end
        in_valid = 0; inj_en = 0; out_ready = 1;
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        check64("loop_drained", sb.size(), 64'd0);
        check64("loop_word_cnt", {48'd0, word_cnt}, {48'd0, model_words});
        check64("loop_inj_cnt", {48'd0, inj_cnt}, {48'd0, model_injs});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sec32_encoder_pipe.md
SEC32_ENCODER_PIPE -- requirements
Module: sec32_encoder_pipe

Interface
REQ-001 Parameter: CNT_W, default 16, width of the encoded-word counter.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port `clk`, input, 1: rising-edge clock.
REQ-004 Port `rst_n`, input, 1: asynchronous active-low reset.
REQ-005 Port `in_valid`, input, 1: upstream word valid.
REQ-006 Port `in_ready`, output, 1: block accepts a word this cycle.
REQ-007 Port `in_data`, input, 32: raw data word; bit k pairs with downstream data input k.
REQ-008 Port `out_valid`, output, 1: encoded word valid.
REQ-009 Port `out_ready`, input, 1: downstream SEC decoder consumes the word.
REQ-010 Port `out_data`, output, 32: data word, possibly with an injected error.
REQ-011 Port `out_check`, output, 8: check bits c[7:0], driving decoder check inputs 0..7.
REQ-012 Port `out_chk_en`, output, 1: decoder check-enable; equals out_valid.
REQ-013 Port `inj_en`, input, 1: error-injection request.
REQ-014 Port `inj_bit`, input, 6: bit to flip; 0–31 selects data, 32–39 selects check bit (inj_bit−32), 40–63 means no flip.
REQ-015 Port `word_cnt`, output, CNT_W: count of completed output handshakes.
REQ-016 Port `inj_cnt`, output, CNT_W: count of accepted words that were actually flipped.

Function
REQ-017 Check bits SHALL be XORs of d=in_data:
- c0 = ^d[23:16] ^ d0^d4^d8^d12
- c1 = ^d[31:24] ^ d1^d5^d9^d13
- c2 = ^d[19:16] ^ ^d[27:24] ^ d2^d6^d10^d14
- c3 = ^d[23:20] ^ ^d[31:28] ^ d3^d7^d11^d15
- c4 = ^d[7:0] ^ d16^d20^d24^d28
- c5 = ^d[15:8] ^ d17^d21^d25^d29
- c6 = ^d[3:0] ^ ^d[11:8] ^ d18^d22^d26^d30
- c7 = ^d[7:4] ^ ^d[15:12] ^ d19^d23^d27^d31
REQ-018 A word SHALL be accepted when in_valid&&in_ready; it SHALL be emitted when out_valid&&out_ready.
REQ-019 Buffering SHALL be a 2-entry skid FSM:
- EMPTY: out_valid=0, in_ready=1.
- ONE: out_valid=1, in_ready=1.
- FULL: out_valid=1, in_ready=0.
REQ-020 FSM transitions:
- Accept-only moves EMPTY→ONE→FULL.
- Emit-only moves FULL→ONE→EMPTY.
- Simultaneous accept and emit in ONE stays in ONE.
- FULL never accepts.
REQ-021 in_ready SHALL be a registered output (no combinational path from out_ready).
REQ-022 Latency SHALL be 1 cycle: a word accepted at edge N is presented on out_* after edge N when the block was EMPTY.
REQ-023 Ordering SHALL be FIFO; out_data/out_check SHALL hold stable while out_valid&&!out_ready.
REQ-024 Check bits SHALL be computed before injection; injection SHALL be sampled at acceptance only, and flips exactly one stored bit when inj_en=1 and inj_bit<40.
REQ-025 inj_en high across several accepts SHALL flip every such word; inj_en with no accept SHALL have no effect.
REQ-026 word_cnt and inj_cnt SHALL wrap from 2^CNT_W−1 to 0 without saturating.

Reset
REQ-027 While rst_n=0:
- FSM is EMPTY; out_valid=0, out_chk_en=0, in_ready=1.
- out_data=0, out_check=0, word_cnt=0, inj_cnt=0.
REQ-028 Reset asserted mid-transfer SHALL discard all buffered words; no partial word SHALL appear after release.
REQ-029 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 A shared package sec32_pkg SHALL hold:
- the DATA_W=32 and CHK_W=8 constants;
- the skid-state enum;
- the check-bit generator as a function, reused by the decoder bench model.
REQ-031 The skid buffer SHALL be one sub-module, sec32_skid, holding 40-bit entries {check,data}.

Verification
REQ-032 Encoding without backpressure:
- in_data=0x00000000 → out_check=0x00.
- in_data=0x00000001 → out_check=0x51.
- in_data=0x80000000 → out_check=0x8A.
- in_data=0xFFFFFFFF → out_check=0x00.
- Each word appears 1 cycle after accept.
REQ-033 out_ready=0 for 3 cycles with in_valid=1:
- Exactly two words accepted; in_ready=0 from the second accept.
- On release, the two words drain in order; word_cnt=2.
REQ-034 Error injection:
- in_data=0x00000001, inj_en=1, inj_bit=5 → out_data=0x00000021, out_check=0x51, inj_cnt=1.
- inj_bit=45 → no flip, inj_cnt unchanged.
REQ-035 Reset while FULL → out_valid=0 and word_cnt=0 immediately; no stale word appears after release.
REQ-036 Closed loop into the decoder with random single-bit injections → decoder output equals the original in_data for 10k words.
